// File: rtl/iob_membus_arbiter.sv
// Two-master, one-slave arbiter for the native valid/ready memory bus.
// Master 0 is the instruction bus, master 1 the data bus. Ties are broken
// round-robin. A grant is held until the slave answers, the granted master
// withdraws its request, or the watchdog forces completion.
module iob_membus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 (instruction bus)
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  // master 1 (data bus)
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  // shared slave port
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  // sticky watchdog expiry flag
  output logic                timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout_err;
  logic             w_timeout_err_nxt;

  // Request fields of the currently selected master.
  logic              w_sel_valid;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [STRB_W-1:0] w_sel_wstrb;
  logic              w_expire;
  logic              w_grant_ready;
  logic [DATA_W-1:0] w_grant_rdata;

  assign w_sel_valid = r_sel ? m1_valid : m0_valid;
  assign w_sel_addr  = r_sel ? m1_addr  : m0_addr;
  assign w_sel_wdata = r_sel ? m1_wdata : m0_wdata;
  assign w_sel_wstrb = r_sel ? m1_wstrb : m0_wstrb;

  assign timeout_err = r_timeout_err;

  // State register: grant, round-robin history, watchdog counter, error flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sel         <= 1'b0;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sel         <= w_sel_nxt;
      r_last        <= w_last_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Next-state decode and bus routing; all outputs are idle outside BUSY.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_sel_nxt         = r_sel;
    w_last_nxt        = r_last;
    w_cnt_nxt         = r_cnt;
    w_timeout_err_nxt = r_timeout_err;
    w_expire          = 1'b0;
    w_grant_ready     = 1'b0;
    w_grant_rdata     = '0;
    s_valid           = 1'b0;
    s_addr            = '0;
    s_wdata           = '0;
    s_wstrb           = '0;
    m0_ready          = 1'b0;
    m0_rdata          = '0;
    m1_ready          = 1'b0;
    m1_rdata          = '0;

    case (r_state)
      ST_IDLE: begin
        // Requests are only sampled here, so s_valid never follows mX_valid
        // combinationally in IDLE.
        if (m0_valid || m1_valid) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = '0;
          if (m0_valid && m1_valid) begin
            w_sel_nxt = ~r_last;
          end else begin
            w_sel_nxt = m1_valid;
          end
        end
      end

      ST_BUSY: begin
        w_expire      = (TIMEOUT != 0) && (r_cnt == CNT_MAX) && !s_ready && w_sel_valid;
        s_valid       = w_sel_valid && !w_expire;
        s_addr        = w_sel_addr;
        s_wdata       = w_sel_wdata;
        s_wstrb       = w_sel_wstrb;
        w_grant_ready = s_ready || w_expire;
        w_grant_rdata = w_expire ? '0 : s_rdata;
        if (r_sel) begin
          m1_ready = w_grant_ready;
          m1_rdata = w_grant_rdata;
        end else begin
          m0_ready = w_grant_ready;
          m0_rdata = w_grant_rdata;
        end

        if (s_ready) begin
          w_last_nxt  = r_sel;
          w_state_nxt = ST_IDLE;
        end else if (!w_sel_valid) begin
          // Master withdrew: drop the grant without touching the history.
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_last_nxt        = r_sel;
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end else if (TIMEOUT != 0) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_membus_arbiter.sv
// Self-checking bench for iob_membus_arbiter. Expected slave requests and
// master responses are queued by the directed test sequence; a monitor pops
// and compares them whenever the DUT accepts on the slave side or returns
// ready to a master. A second instance with TIMEOUT=4 covers the watchdog.
module tb_iob_membus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;

  logic          m0_valid, m1_valid;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] s_rdata;
  logic          s_ready;
  logic          timeout_err;

  logic          wd_m0_valid, wd_m1_valid;
  logic [AW-1:0] wd_m0_addr, wd_m1_addr;
  logic [DW-1:0] wd_m0_wdata, wd_m1_wdata;
  logic [SW-1:0] wd_m0_wstrb, wd_m1_wstrb;
  logic [DW-1:0] wd_m0_rdata, wd_m1_rdata;
  logic          wd_m0_ready, wd_m1_ready;
  logic          wd_s_valid;
  logic [AW-1:0] wd_s_addr;
  logic [DW-1:0] wd_s_wdata;
  logic [SW-1:0] wd_s_wstrb;
  logic [DW-1:0] wd_s_rdata;
  logic          wd_s_ready;
  logic          wd_timeout_err;

  iob_membus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .timeout_err(timeout_err)
  );

  iob_membus_arbiter #(.TIMEOUT(4)) dut_wd (
    .clk(clk), .rst(rst),
    .m0_valid(wd_m0_valid), .m0_addr(wd_m0_addr), .m0_wdata(wd_m0_wdata), .m0_wstrb(wd_m0_wstrb),
    .m0_rdata(wd_m0_rdata), .m0_ready(wd_m0_ready),
    .m1_valid(wd_m1_valid), .m1_addr(wd_m1_addr), .m1_wdata(wd_m1_wdata), .m1_wstrb(wd_m1_wstrb),
    .m1_rdata(wd_m1_rdata), .m1_ready(wd_m1_ready),
    .s_valid(wd_s_valid), .s_addr(wd_s_addr), .s_wdata(wd_s_wdata), .s_wstrb(wd_s_wstrb),
    .s_rdata(wd_s_rdata), .s_ready(wd_s_ready),
    .timeout_err(wd_timeout_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } s_exp_t;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
  } m_exp_t;

  s_exp_t exp_s[$];
  m_exp_t exp_m[$];
  int     acc_cyc[$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            slv_wait = 0;
  logic [DW-1:0] slv_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic expect_txn(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [DW-1:0] rd);
    s_exp_t es;
    m_exp_t em;
    es.addr = a; es.wdata = d; es.wstrb = s;
    em.id = id; em.rdata = rd;
    exp_s.push_back(es);
    exp_m.push_back(em);
  endtask

  // Drive a request on master m and hold it until that master sees ready.
  // Called at posedge+2; returns at the following posedge+2 with valid still high.
  task automatic issue(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, output int lat);
    logic got;
    if (m == 0) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = (m == 0) ? m0_ready : m1_ready;
    end
    check($sformatf("issue_m%0d_done", m), got, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int m);
    if (m == 0) begin
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    end else begin
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    end
  endtask

  // Slave model: answers slv_wait cycles after s_valid first appears.
  always begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      s_rdata = '0;
      if (s_valid) begin
        if (wcnt == slv_wait) begin
          s_ready = 1'b1;
          s_rdata = slv_rdata;
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compares each slave acceptance and each master response.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && s_ready) begin
        check("s_accept_expected", exp_s.size() != 0, 1);
        if (exp_s.size() != 0) begin
          s_exp_t es;
          es = exp_s.pop_front();
          check("s_addr", s_addr, es.addr);
          check("s_wdata", s_wdata, es.wdata);
          check("s_wstrb", s_wstrb, es.wstrb);
        end
        acc_cyc.push_back(cyc);
      end
      if (m0_ready || m1_ready) begin
        check("single_ready", m0_ready & m1_ready, 0);
        check("m_ready_expected", exp_m.size() != 0, 1);
        if (exp_m.size() != 0) begin
          m_exp_t em;
          em = exp_m.pop_front();
          check("grant_id", m1_ready ? 1 : 0, em.id);
          check("m_rdata", m1_ready ? m1_rdata : m0_rdata, em.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    s_ready = 1'b0; s_rdata = '0;
    idle(0); idle(1);
    wd_m0_valid = 1'b0; wd_m0_addr = '0; wd_m0_wdata = '0; wd_m0_wstrb = '0;
    wd_m1_valid = 1'b0; wd_m1_addr = '0; wd_m1_wdata = '0; wd_m1_wstrb = '0;
    wd_s_ready = 1'b0; wd_s_rdata = '0;

    // ---- reset / idle ----
    repeat (2) @(posedge clk);
    #2;
    check("rst_s_valid", s_valid, 0);
    check("rst_ready", {m0_ready, m1_ready}, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    slv_wait = 20;
    m0_valid = 1'b1; m0_addr = 32'h40;
    @(posedge clk);
    #2;
    check("grant_s_valid", s_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_s_valid", s_valid, 0);
    check("async_rst_s_addr", s_addr, 0);
    check("async_rst_m0", {m0_ready, m0_rdata}, 0);
    check("async_rst_err", timeout_err, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", s_valid, 0);
    @(negedge clk);
    check("post_rst_grant", s_valid, 1);
    check("post_rst_addr", s_addr, 32'h40);
    @(posedge clk);
    #2;
    idle(0);
    @(negedge clk);
    check("post_rst_abort", s_valid, 0);
    repeat (2) @(posedge clk);
    #2;

    // ---- single read from m1 with two wait states ----
    slv_wait  = 2;
    slv_rdata = 32'hCAFEBABE;
    expect_txn(1, 32'h100, 32'h0, 4'h0, 32'hCAFEBABE);
    issue(1, 32'h100, 32'h0, 4'h0, lat);
    idle(1);
    check("read_latency", lat, 4);

    // ---- contention, zero-wait slave ----
    @(posedge clk);
    #2;
    slv_wait  = 0;
    slv_rdata = 32'h12345678;
    acc_cyc.delete();
    for (int i = 0; i < 2; i++) begin
      expect_txn(0, 32'h10, 32'h11, 4'hF, 32'h12345678);
      expect_txn(1, 32'h20, 32'h0, 4'h0, 32'h12345678);
    end
    fork
      begin
        int l0;
        issue(0, 32'h10, 32'h11, 4'hF, l0);
        issue(0, 32'h10, 32'h11, 4'hF, l0);
        idle(0);
      end
      begin
        int l1;
        issue(1, 32'h20, 32'h0, 4'h0, l1);
        issue(1, 32'h20, 32'h0, 4'h0, l1);
        idle(1);
      end
    join
    check("contention_count", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("contention_spacing", acc_cyc[i] - acc_cyc[i-1], 2);

    // ---- grant hold with a 5-wait-state slave ----
    @(posedge clk);
    #2;
    slv_wait  = 5;
    slv_rdata = 32'hA5A5A5A5;
    expect_txn(0, 32'h300, 32'hDEAD, 4'h3, 32'hA5A5A5A5);
    expect_txn(1, 32'h400, 32'h0, 4'h0, 32'hA5A5A5A5);
    fork
      begin
        int l0;
        issue(0, 32'h300, 32'hDEAD, 4'h3, l0);
        idle(0);
      end
      begin
        int l1;
        repeat (2) @(posedge clk);
        #2;
        issue(1, 32'h400, 32'h0, 4'h0, l1);
        idle(1);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("hold_s_addr", s_addr, 32'h300);
        end
      end
    join

    // ---- abort: m0 completes, then m1 withdraws mid-transaction ----
    @(posedge clk);
    #2;
    slv_wait  = 0;
    slv_rdata = 32'h0BADF00D;
    expect_txn(0, 32'h500, 32'h0, 4'h0, 32'h0BADF00D);
    issue(0, 32'h500, 32'h0, 4'h0, lat);
    idle(0);
    @(posedge clk);
    #2;
    slv_wait = 20;
    m1_valid = 1'b1; m1_addr = 32'h700;
    repeat (3) @(posedge clk);
    #2;
    m1_valid = 1'b0;
    @(negedge clk);
    check("abort_s_valid", s_valid, 0);
    check("abort_no_ready", m1_ready, 0);
    @(negedge clk);
    check("abort_idle_s_addr", s_addr, 0);
    @(posedge clk);
    #2;
    idle(1);
    slv_wait  = 0;
    slv_rdata = 32'h600D600D;
    expect_txn(1, 32'h20, 32'h0, 4'h0, 32'h600D600D);
    expect_txn(0, 32'h10, 32'h11, 4'hF, 32'h600D600D);
    fork
      begin
        int l0;
        issue(0, 32'h10, 32'h11, 4'hF, l0);
        idle(0);
      end
      begin
        int l1;
        issue(1, 32'h20, 32'h0, 4'h0, l1);
        idle(1);
      end
    join

    // ---- watchdog (TIMEOUT=4 instance) ----
    @(posedge clk);
    #2;
    wd_m0_valid = 1'b1; wd_m0_addr = 32'h500; wd_m0_wdata = 32'h55; wd_m0_wstrb = 4'h1;
    wd_s_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("wd_wait_ready", wd_m0_ready, 0);
      check("wd_wait_s_valid", wd_s_valid, 1);
    end
    @(negedge clk);
    check("wd_forced_ready", wd_m0_ready, 1);
    check("wd_forced_rdata", wd_m0_rdata, 0);
    check("wd_forced_s_valid", wd_s_valid, 0);
    check("wd_other_ready", {wd_m1_ready, wd_m1_rdata}, 0);
    check("wd_s_fields", {wd_s_addr, wd_s_wdata, wd_s_wstrb}, {32'h500, 32'h55, 4'h1});
    check("wd_err_before_edge", wd_timeout_err, 0);
    @(posedge clk);
    #2;
    wd_m0_valid = 1'b0;
    wd_s_ready  = 1'b1;
    @(negedge clk);
    check("wd_err_set", wd_timeout_err, 1);
    check("wd_late_ready_ignored", wd_m0_ready, 0);
    @(posedge clk);
    #2;
    wd_s_ready  = 1'b0;
    wd_m0_valid = 1'b1; wd_m0_addr = 32'h600; wd_m0_wdata = '0; wd_m0_wstrb = '0;
    wd_s_rdata  = 32'h77;
    @(posedge clk);
    #2;
    wd_s_ready = 1'b1;
    @(negedge clk);
    check("wd_next_ready", wd_m0_ready, 1);
    check("wd_next_rdata", wd_m0_rdata, 32'h77);
    check("wd_next_addr", wd_s_addr, 32'h600);
    check("wd_err_sticky", wd_timeout_err, 1);
    @(posedge clk);
    #2;
    wd_m0_valid = 1'b0;
    wd_s_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    check("main_no_timeout", timeout_err, 0);
    check("exp_s_drained", exp_s.size(), 0);
    check("exp_m_drained", exp_m.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iob_membus_arbiter.md
# iob_membus_arbiter

Two-master, one-slave arbiter for the native valid/ready memory bus. It merges the CPU instruction and data buses onto a single shared memory port, such as one unified RAM or an external-memory controller. Grants are round-robin and held for the whole transaction. A watchdog terminates transactions the slave never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width of masters and slave.
- DATA_W, 32, data width. The strobe width is DATA_W/8.
- TIMEOUT, 255, number of BUSY cycles without s_ready before forced completion. 0 disables the watchdog.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- m0_valid / m0_addr / m0_wdata / m0_wstrb, in, 1 / ADDR_W / DATA_W / DATA_W/8, master 0 request (instruction bus).
- m0_rdata / m0_ready, out, DATA_W / 1, master 0 response.
- m1_valid / m1_addr / m1_wdata / m1_wstrb, in, same widths, master 1 request (data bus).
- m1_rdata / m1_ready, out, DATA_W / 1, master 1 response.
- s_valid / s_addr / s_wdata / s_wstrb, out, 1 / ADDR_W / DATA_W / DATA_W/8, slave request.
- s_rdata / s_ready, in, DATA_W / 1, slave response.
- timeout_err, out, 1, sticky flag: a watchdog expiry has occurred.

## Operation
Bus protocol:
- A master raises valid and holds addr, wdata and wstrb stable until it sees ready for one cycle.
- wstrb==0 means read. Any nonzero wstrb means write.

State machine (IDLE, BUSY):
- IDLE:
  - s_valid=0. Both mX_ready=0.
  - If any mX_valid=1, register sel and move to BUSY.
  - Only one valid: sel = that master.
  - Both valid: sel = the master not granted last (register last, reset value 1, so master 0 wins the first tie).
- BUSY:
  - s_valid = m[sel]_valid; s_addr, s_wdata and s_wstrb come combinationally from m[sel].
  - m[sel]_ready = s_ready; m[sel]_rdata = s_rdata.
  - The non-selected master sees ready=0 and rdata=0.
  - On s_ready=1: last<=sel, move to IDLE.
- Abort: if m[sel]_valid drops in BUSY without s_ready, go to IDLE. No ready is issued and last is not updated.
- Watchdog:
  - Counter cnt (width $clog2(TIMEOUT+1)) clears on entering BUSY and increments each BUSY cycle without s_ready.
  - When cnt==TIMEOUT and s_ready=0: force m[sel]_ready=1 with m[sel]_rdata=0, deassert s_valid that cycle, set timeout_err, last<=sel, move to IDLE.
  - A late s_ready arriving in IDLE is ignored.
- timeout_err clears only on rst.
- Slave-side outputs are zero whenever the arbiter is not in BUSY.

## Timing
- Reset (async, asserted): state=IDLE, sel=0, last=1, cnt=0, timeout_err=0.
  - All outputs are 0 immediately, not at the next edge.
- Reset mid-transaction: the transaction is dropped with no ready to any master. After release, arbitration restarts with master 0 priority.
- Grant latency: mX_valid sampled in IDLE at edge N gives s_valid=1 in cycle N+1.
- Completion: s_ready in cycle K returns mX_ready in the same cycle K. IDLE follows in K+1.
- Throughput: with a zero-wait slave, one transaction per 2 cycles. There is one IDLE bubble between grants.
- Back-to-back from the same master while the other is idle: re-granted after the bubble.
- Both requesting continuously: strict alternation 0,1,0,1 …
- The grant never changes while BUSY, even if the other master raises valid.
- Watchdog: forced ready occurs in BUSY cycle TIMEOUT+1 counted from the grant. TIMEOUT=0 means wait forever.
- No combinational path from mX_valid to s_valid in IDLE. s_ready → mX_ready is combinational.

## Test plan
- Reset/idle:
  - Stimulus: assert rst mid-cycle with m0_valid=1.
  - Required: all outputs 0 asynchronously; after release, s_valid=1 exactly 1 cycle after m0_valid is sampled.
- Single read:
  - Stimulus: m1 requests addr=0x100, wstrb=0; slave answers 2 cycles later with rdata=0xCAFEBABE.
  - Required: m1_ready=1 and m1_rdata=0xCAFEBABE in that cycle; m0_ready=0 throughout.
- Contention:
  - Stimulus: both masters hold valid for 4 transactions, zero-wait slave. m0 writes addr=0x10 with wdata=0x11; m1 reads addr=0x20.
  - Required: grant order 0,1,0,1; s_addr alternates 0x10/0x20; s_wstrb=0xF only for m0; one transaction per 2 cycles.
- Grant hold:
  - Stimulus: m0 is granted with a 5-wait-state slave; m1 raises valid during the wait.
  - Required: s_addr stays at m0_addr until s_ready; m1 is served next.
- Watchdog:
  - Stimulus: TIMEOUT=4, slave never readies.
  - Required: m0_ready=1 with rdata=0 in BUSY cycle 5; timeout_err=1 and remains set; the next request is arbitrated normally.
- Abort:
  - Stimulus: m1 drops valid while BUSY, before s_ready.
  - Required: no m1_ready; return to IDLE; the next tie goes to m1 (last unchanged).
